// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares a single memory port between instruction fetch (IF) and the
//   load/store unit (LS).
//
//   Only one transaction is in flight at a time. LS normally wins arbitration.
//   After MAX_LS_STREAK consecutive LS grants while IF was waiting, IF gets the
//   next grant.
//
// Transaction timeline (gnt in cycle N, mem_ack in cycle N+k):
//   - mem_req is high in cycles N+1..N+k.
//   - The owner's rvalid is high in cycle N+k+1.
//   - The next grant comes no earlier than cycle N+k+2.
//
// Ports:
//   clk, rst         clock; asynchronous active-high reset
//   if_req/if_addr   fetch request, held until if_gnt
//   if_gnt           fetch accepted (combinational pulse)
//   if_rvalid/rdata  fetch data return (registered pulse / held data)
//   ls_req/we/addr/wdata/wmask
//                    load/store request, held until ls_gnt
//   ls_gnt           load/store accepted (combinational pulse)
//   ls_rvalid/rdata  load/store completion; rdata is 0 for stores
//   mem_req/we/addr/wdata/wmask
//                    registered downstream request, stable until mem_ack
//   mem_ack/rdata    downstream completion; data valid with ack
//
// Optional build macro MEM_ARB_TIMEOUT_EN:
//   - Adds parameter TIMEOUT and a sticky bus_err output.
//   - A transaction that sees no mem_ack for TIMEOUT busy cycles is
//     abandoned.
//   - Its owner then receives an rvalid pulse with all-ones rdata.
module mem_port_arbiter #(
    parameter int ADDR_W        = 64,
    parameter int DATA_W        = 64,
    parameter int MAX_LS_STREAK = 4
`ifdef MEM_ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT       = 255
`endif
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                ls_req,
    input  logic                ls_we,
    input  logic [ADDR_W-1:0]   ls_addr,
    input  logic [DATA_W-1:0]   ls_wdata,
    input  logic [DATA_W/8-1:0] ls_wmask,
    output logic                ls_gnt,
    output logic                ls_rvalid,
    output logic [DATA_W-1:0]   ls_rdata,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic                mem_ack,
    input  logic [DATA_W-1:0]   mem_rdata
`ifdef MEM_ARB_TIMEOUT_EN
    ,
    output logic                bus_err
`endif
);

    localparam int       MASK_W     = DATA_W / 8;
    localparam bit [3:0] STREAK_MAX = 4'(MAX_LS_STREAK);

    // The BUSY state also identifies the owner of the transaction in flight.
    typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_LS, RESP} state_e;

    state_e              state_q, state_d;
    logic [3:0]          streak_q, streak_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [MASK_W-1:0]   mem_wmask_q, mem_wmask_d;
    logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]   ls_rdata_q, ls_rdata_d;
    logic                if_rvalid_q, if_rvalid_d;
    logic                ls_rvalid_q, ls_rvalid_d;
    logic                if_gnt_c, ls_gnt_c;
    logic                busy;
    logic                timeout_hit;

    assign busy = (state_q == BUSY_IF) || (state_q == BUSY_LS);

`ifdef MEM_ARB_TIMEOUT_EN
    logic [7:0] tmo_cnt_q, tmo_cnt_d;
    logic       bus_err_q, bus_err_d;

    // The counter restarts at zero on entry to BUSY.
    // It hits TIMEOUT-1 on the TIMEOUT-th busy cycle without an ack.
    assign timeout_hit = busy && !mem_ack && (tmo_cnt_q == 8'(TIMEOUT - 1));

    always_comb begin
        tmo_cnt_d = busy ? tmo_cnt_q + 8'd1 : 8'd0;
        bus_err_d = bus_err_q | timeout_hit;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt_q <= 8'd0;
            bus_err_q <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            bus_err_q <= bus_err_d;
        end
    end

    assign bus_err = bus_err_q;
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        // NOTE: every signal gets a default before the case statement.
        // This way no path leaves a value unassigned, so no latch can be
        // inferred.
        state_d     = state_q;
        streak_d    = streak_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wmask_d = mem_wmask_q;
        if_rdata_d  = if_rdata_q;
        ls_rdata_d  = ls_rdata_q;
        if_rvalid_d = 1'b0;
        ls_rvalid_d = 1'b0;
        if_gnt_c    = 1'b0;
        ls_gnt_c    = 1'b0;

        case (state_q)
            IDLE: begin
                // LS wins unless IF has already waited out a full streak.
                if (ls_req && !(if_req && streak_q == STREAK_MAX)) begin
                    ls_gnt_c    = 1'b1;
                    state_d     = BUSY_LS;
                    mem_req_d   = 1'b1;
                    mem_we_d    = ls_we;
                    mem_addr_d  = ls_addr;
                    mem_wdata_d = ls_wdata;
                    mem_wmask_d = ls_wmask;
                    if (!if_req)
                        streak_d = 4'd0;
                    else if (streak_q != STREAK_MAX)
                        streak_d = streak_q + 4'd1;
                end else if (if_req) begin
                    if_gnt_c    = 1'b1;
                    state_d     = BUSY_IF;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = if_addr;
                    mem_wdata_d = '0;
                    mem_wmask_d = '0;
                    streak_d    = 4'd0;
                end
            end
            BUSY_IF, BUSY_LS: begin
                if (mem_ack || timeout_hit) begin
                    mem_req_d = 1'b0;
                    state_d   = RESP;
                    if (state_q == BUSY_IF) begin
                        if_rvalid_d = 1'b1;
                        if_rdata_d  = mem_ack ? mem_rdata : '1;
                    end else begin
                        ls_rvalid_d = 1'b1;
                        if (!mem_ack)
                            ls_rdata_d = '1;
                        else
                            ls_rdata_d = mem_we_q ? '0 : mem_rdata;
                    end
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments.
    // Every flop then samples pre-edge values, whatever the evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            streak_q    <= 4'd0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wmask_q <= '0;
            if_rdata_q  <= '0;
            ls_rdata_q  <= '0;
            if_rvalid_q <= 1'b0;
            ls_rvalid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            streak_q    <= streak_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wmask_q <= mem_wmask_d;
            if_rdata_q  <= if_rdata_d;
            ls_rdata_q  <= ls_rdata_d;
            if_rvalid_q <= if_rvalid_d;
            ls_rvalid_q <= ls_rvalid_d;
        end
    end

    assign if_gnt    = if_gnt_c;
    assign ls_gnt    = ls_gnt_c;
    assign if_rvalid = if_rvalid_q;
    assign ls_rvalid = ls_rvalid_q;
    assign if_rdata  = if_rdata_q;
    assign ls_rdata  = ls_rdata_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wmask = mem_wmask_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    localparam int MAXS = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [63:0] if_addr = '0;
    logic        if_gnt, if_rvalid;
    logic [63:0] if_rdata;
    logic        ls_req = 1'b0, ls_we = 1'b0;
    logic [63:0] ls_addr = '0, ls_wdata = '0;
    logic [7:0]  ls_wmask = '0;
    logic        ls_gnt, ls_rvalid;
    logic [63:0] ls_rdata;
    logic        mem_req, mem_we;
    logic [63:0] mem_addr, mem_wdata;
    logic [7:0]  mem_wmask;
    logic        mem_ack;
    logic [63:0] mem_rdata;
`ifdef MEM_ARB_TIMEOUT_EN
    logic        bus_err;
`endif

    // Memory side: either a scripted ack (man_*) or an automatic responder.
    bit          mem_auto = 1'b0;
    logic        man_ack = 1'b0;
    logic [63:0] man_rdata = '0;
    logic        auto_ack = 1'b0;
    logic [63:0] auto_rdata = '0;
    int          mem_lat_max = 0;
    int          wait_cnt = 0;
    int          cur_lat = 0;

    assign mem_ack   = mem_auto ? auto_ack : man_ack;
    assign mem_rdata = mem_auto ? auto_rdata : man_rdata;

    int total = 0;
    int bad = 0;

    mem_port_arbiter #(
        .ADDR_W(64), .DATA_W(64), .MAX_LS_STREAK(MAXS)
`ifdef MEM_ARB_TIMEOUT_EN
        , .TIMEOUT(8)
`endif
    ) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr),
        .ls_wdata(ls_wdata), .ls_wmask(ls_wmask), .ls_gnt(ls_gnt),
        .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
`ifdef MEM_ARB_TIMEOUT_EN
        , .bus_err(bus_err)
`endif
    );

    always #5 clk = ~clk;

    // Memory contents are a fixed function of the address.
    function automatic logic [63:0] mem_word(input logic [63:0] a);
        return {a[31:0], ~a[63:32]} ^ 64'h0123_4567_89AB_CDEF;
    endfunction

    // Automatic responder: acks after cur_lat extra cycles of mem_req.
    always @(negedge clk) begin
        auto_ack = 1'b0;
        if (mem_auto && mem_req) begin
            if (wait_cnt >= cur_lat) begin
                auto_ack   = 1'b1;
                auto_rdata = mem_word(mem_addr);
                wait_cnt   = 0;
                cur_lat    = $urandom_range(0, mem_lat_max);
            end else begin
                wait_cnt++;
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1; if_req = 1'b0; ls_req = 1'b0; man_ack = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        total++; if ({if_gnt, ls_gnt, if_rvalid, ls_rvalid, mem_req, mem_we} !== 6'b0) begin bad++; $display("FAIL reset.ctrl got=%b exp=000000", {if_gnt, ls_gnt, if_rvalid, ls_rvalid, mem_req, mem_we}); end
        total++; if ({if_rdata, ls_rdata} !== 128'b0) begin bad++; $display("FAIL reset.rdata got=%h_%h exp=0", if_rdata, ls_rdata); end
        total++; if ({mem_addr, mem_wdata, mem_wmask} !== 136'b0) begin bad++; $display("FAIL reset.membus got=%h %h %h exp=0", mem_addr, mem_wdata, mem_wmask); end
        @(negedge clk); rst = 1'b0;
        @(negedge clk); #1;
        total++; if ({if_gnt, ls_gnt, mem_req} !== 3'b0) begin bad++; $display("FAIL reset.idle got=%b exp=000", {if_gnt, ls_gnt, mem_req}); end
    endtask

    task automatic test_if_read();
        @(negedge clk); if_req = 1'b1; if_addr = 64'h8000_0000; #1;
        total++; if ({if_gnt, ls_gnt, mem_req} !== 3'b100) begin bad++; $display("FAIL if_read.gnt got=%b exp=100", {if_gnt, ls_gnt, mem_req}); end
        @(negedge clk); if_req = 1'b0; #1;
        total++; if ({if_gnt, mem_req, mem_we} !== 3'b010) begin bad++; $display("FAIL if_read.req got=%b exp=010", {if_gnt, mem_req, mem_we}); end
        total++; if (mem_addr !== 64'h8000_0000 || mem_wmask !== 8'h00) begin bad++; $display("FAIL if_read.addr got=%h/%h exp=80000000/00", mem_addr, mem_wmask); end
        @(negedge clk); #1;
        total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL if_read.req2 got=%b exp=1", mem_req); end
        @(negedge clk); man_ack = 1'b1; man_rdata = 64'h0000_0513; #1;
        total++; if (mem_req !== 1'b1 || if_rvalid !== 1'b0) begin bad++; $display("FAIL if_read.req3 got=%b%b exp=10", mem_req, if_rvalid); end
        @(negedge clk); man_ack = 1'b0; man_rdata = '0; #1;
        total++; if ({mem_req, if_rvalid, ls_rvalid} !== 3'b010) begin bad++; $display("FAIL if_read.rvalid got=%b exp=010", {mem_req, if_rvalid, ls_rvalid}); end
        total++; if (if_rdata !== 64'h0000_0513) begin bad++; $display("FAIL if_read.rdata got=%h exp=513", if_rdata); end
        @(negedge clk); #1;
        total++; if (if_rvalid !== 1'b0 || if_rdata !== 64'h0000_0513) begin bad++; $display("FAIL if_read.hold got=%b/%h exp=0/513", if_rvalid, if_rdata); end
    endtask

    task automatic test_store();
        @(negedge clk);
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 64'h8000_1000;
        ls_wdata = 64'h1122_3344_5566_7788; ls_wmask = 8'h0F; #1;
        total++; if ({ls_gnt, if_gnt} !== 2'b10) begin bad++; $display("FAIL store.gnt got=%b exp=10", {ls_gnt, if_gnt}); end
        @(negedge clk); ls_req = 1'b0; ls_we = 1'b0; ls_wmask = 8'hFF; #1;
        total++; if ({mem_req, mem_we, mem_wmask} !== {2'b11, 8'h0F}) begin bad++; $display("FAIL store.ctl got=%b%b/%h exp=11/0f", mem_req, mem_we, mem_wmask); end
        total++; if (mem_addr !== 64'h8000_1000 || mem_wdata !== 64'h1122_3344_5566_7788) begin bad++; $display("FAIL store.bus got=%h/%h exp=80001000/1122334455667788", mem_addr, mem_wdata); end
        @(negedge clk); man_ack = 1'b1; man_rdata = 64'hDEAD_BEEF_CAFE_F00D; #1;
        total++; if ({mem_req, mem_we, mem_wmask} !== {2'b11, 8'h0F}) begin bad++; $display("FAIL store.stable got=%b%b/%h exp=11/0f", mem_req, mem_we, mem_wmask); end
        @(negedge clk); man_ack = 1'b0; #1;
        total++; if ({ls_rvalid, if_rvalid, mem_req} !== 3'b100) begin bad++; $display("FAIL store.rvalid got=%b exp=100", {ls_rvalid, if_rvalid, mem_req}); end
        total++; if (ls_rdata !== 64'h0) begin bad++; $display("FAIL store.rdata got=%h exp=0", ls_rdata); end
        @(negedge clk); #1;
        total++; if (ls_rvalid !== 1'b0) begin bad++; $display("FAIL store.pulse got=%b exp=0", ls_rvalid); end
    endtask

    // Both requesters always pending with a 1-cycle memory.
    // Expected pattern: MAXS LS grants, then one IF grant, repeating.
    // Grants come every 3 cycles.
    task automatic test_streak();
        int g = 0;
        int last = 0;
        do_reset();
        mem_auto = 1'b1; mem_lat_max = 0;
        @(negedge clk);
        if_req = 1'b1; if_addr = 64'h100; ls_req = 1'b1; ls_we = 1'b0; ls_addr = 64'h200;
        for (int cyc = 0; cyc < 100 && g < 15; cyc++) begin
            if (cyc != 0) @(negedge clk);
            #1;
            total++; if (if_gnt && ls_gnt) begin bad++; $display("FAIL streak.excl got=11 exp=one-hot"); end
            if (if_gnt || ls_gnt) begin
                automatic bit exp_ls = (g % (MAXS + 1)) != MAXS;
                total++; if (ls_gnt !== exp_ls || if_gnt !== !exp_ls) begin bad++; $display("FAIL streak.order grant=%0d got_ls=%b exp_ls=%b", g, ls_gnt, exp_ls); end
                if (g > 0) begin
                    total++; if (cyc - last != 3) begin bad++; $display("FAIL streak.gap got=%0d exp=3", cyc - last); end
                end
                last = cyc;
                g++;
            end
        end
        total++; if (g != 15) begin bad++; $display("FAIL streak.count got=%0d exp=15", g); end
        @(negedge clk); if_req = 1'b0; ls_req = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    // Random traffic against a transaction-level scoreboard.
    task automatic test_random();
        bit          pend = 0, pend_ls = 0, pend_we = 0;
        logic [63:0] pend_addr = '0, pend_wdata = '0;
        logic [7:0]  pend_wmask = '0;
        int          run = 0, age = 0, ngrant = 0;
        bit          rel_if = 0, rel_ls = 0;
        do_reset();
        mem_auto = 1'b1; mem_lat_max = 3;
        for (int cyc = 0; cyc < 360; cyc++) begin
            bit resp_now;
            bit exp_ls_g, exp_if_g;
            @(negedge clk);
            if (rel_if) if_req = 1'b0;
            if (rel_ls) ls_req = 1'b0;
            if (cyc < 320) begin
                if (!if_req && $urandom_range(0, 2) == 0) begin
                    if_req = 1'b1; if_addr = {$urandom, $urandom};
                end
                if (!ls_req && $urandom_range(0, 1) == 0) begin
                    ls_req = 1'b1; ls_we = $urandom_range(0, 1) == 1;
                    ls_addr = {$urandom, $urandom}; ls_wdata = {$urandom, $urandom};
                    ls_wmask = 8'($urandom);
                end
            end
            #1;
            resp_now = 1'b0;
            total++; if (if_rvalid && ls_rvalid) begin bad++; $display("FAIL random.rv_excl got=11 exp=one-hot"); end
            if (if_rvalid || ls_rvalid) begin
                resp_now = 1'b1;
                total++; if (!pend || ls_rvalid !== pend_ls) begin bad++; $display("FAIL random.rv_owner got_ls=%b exp_ls=%b pend=%b", ls_rvalid, pend_ls, pend); end
                if (pend && !pend_ls) begin
                    total++; if (if_rdata !== mem_word(pend_addr)) begin bad++; $display("FAIL random.if_rdata got=%h exp=%h", if_rdata, mem_word(pend_addr)); end
                end
                if (pend && pend_ls) begin
                    automatic logic [63:0] exp_d = pend_we ? 64'h0 : mem_word(pend_addr);
                    total++; if (ls_rdata !== exp_d) begin bad++; $display("FAIL random.ls_rdata got=%h exp=%h", ls_rdata, exp_d); end
                end
                pend = 1'b0;
            end else if (pend) begin
                age++;
                total++; if (mem_req !== 1'b1 || mem_addr !== pend_addr || mem_we !== pend_we) begin bad++; $display("FAIL random.membus got=%b/%h/%b exp=1/%h/%b", mem_req, mem_addr, mem_we, pend_addr, pend_we); end
                total++; if (mem_wdata !== pend_wdata || mem_wmask !== pend_wmask) begin bad++; $display("FAIL random.memdata got=%h/%h exp=%h/%h", mem_wdata, mem_wmask, pend_wdata, pend_wmask); end
                total++; if (age > 8) begin bad++; $display("FAIL random.timeout got=%0d exp<=8", age); pend = 1'b0; end
            end
            // Arbitration: only possible when nothing is in flight or responding.
            exp_ls_g = !pend && !resp_now && ls_req && !(if_req && run == MAXS);
            exp_if_g = !pend && !resp_now && if_req && !exp_ls_g;
            total++; if (ls_gnt !== exp_ls_g || if_gnt !== exp_if_g) begin bad++; $display("FAIL random.gnt cyc=%0d got=%b%b exp=%b%b", cyc, ls_gnt, if_gnt, exp_ls_g, exp_if_g); end
            rel_if = 1'b0; rel_ls = 1'b0;
            if (exp_ls_g) begin
                pend = 1; pend_ls = 1; pend_we = ls_we; pend_addr = ls_addr;
                pend_wdata = ls_wdata; pend_wmask = ls_wmask; age = 0; rel_ls = 1; ngrant++;
                run = if_req ? ((run < MAXS) ? run + 1 : MAXS) : 0;
            end else if (exp_if_g) begin
                pend = 1; pend_ls = 0; pend_we = 0; pend_addr = if_addr;
                pend_wdata = '0; pend_wmask = '0; age = 0; rel_if = 1; ngrant++;
                run = 0;
            end
        end
        total++; if (pend || if_req || ls_req || ngrant < 40) begin bad++; $display("FAIL random.drain got=pend%b req%b%b grants=%0d exp=idle,>=40", pend, if_req, ls_req, ngrant); end
        @(negedge clk); if_req = 1'b0; ls_req = 1'b0;
        repeat (3) @(negedge clk);
        mem_auto = 1'b0;
    endtask

    task automatic test_reset_mid();
        @(negedge clk); if_req = 1'b1; if_addr = 64'h4000; #1;
        total++; if (if_gnt !== 1'b1) begin bad++; $display("FAIL rst_mid.gnt got=%b exp=1", if_gnt); end
        @(negedge clk); if_req = 1'b0; #1;
        total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL rst_mid.req got=%b exp=1", mem_req); end
        #2 rst = 1'b1; #1;
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL rst_mid.async got=%b exp=0", mem_req); end
        @(negedge clk); rst = 1'b0; man_ack = 1'b1; man_rdata = 64'h5555; #1;
        total++; if ({if_rvalid, ls_rvalid, mem_req} !== 3'b0) begin bad++; $display("FAIL rst_mid.late_ack got=%b exp=000", {if_rvalid, ls_rvalid, mem_req}); end
        @(negedge clk); man_ack = 1'b0; #1;
        total++; if ({if_rvalid, ls_rvalid, mem_req} !== 3'b0) begin bad++; $display("FAIL rst_mid.no_rv got=%b exp=000", {if_rvalid, ls_rvalid, mem_req}); end
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 64'h6000; #1;
        total++; if (ls_gnt !== 1'b1) begin bad++; $display("FAIL rst_mid.idle_gnt got=%b exp=1", ls_gnt); end
        @(negedge clk); ls_req = 1'b0; man_ack = 1'b1; man_rdata = 64'hA1B2_C3D4; #1;
        @(negedge clk); man_ack = 1'b0; #1;
        total++; if (ls_rvalid !== 1'b1 || ls_rdata !== 64'hA1B2_C3D4) begin bad++; $display("FAIL rst_mid.after got=%b/%h exp=1/a1b2c3d4", ls_rvalid, ls_rdata); end
        @(negedge clk);
    endtask

    task automatic test_spurious_ack();
        @(negedge clk); man_ack = 1'b1; man_rdata = 64'hFFFF_0000;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            total++; if ({if_rvalid, ls_rvalid, mem_req} !== 3'b0) begin bad++; $display("FAIL spurious.ack%0d got=%b exp=000", i, {if_rvalid, ls_rvalid, mem_req}); end
        end
        man_ack = 1'b0;
        @(negedge clk);
    endtask

`ifdef MEM_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int n = 0;
        do_reset();
        #1;
        total++; if (bus_err !== 1'b0) begin bad++; $display("FAIL timeout.init got=%b exp=0", bus_err); end
        @(negedge clk); if_req = 1'b1; if_addr = 64'h7000; #1;
        total++; if (if_gnt !== 1'b1) begin bad++; $display("FAIL timeout.gnt got=%b exp=1", if_gnt); end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); if_req = 1'b0; #1;
            if (mem_req) n++;
            else break;
        end
        total++; if (n != 8) begin bad++; $display("FAIL timeout.cycles got=%0d exp=8", n); end
        total++; if (if_rvalid !== 1'b1 || if_rdata !== 64'hFFFF_FFFF_FFFF_FFFF || bus_err !== 1'b1) begin bad++; $display("FAIL timeout.resp got=%b/%h/%b exp=1/ffffffffffffffff/1", if_rvalid, if_rdata, bus_err); end
        repeat (3) @(negedge clk);
        #1;
        total++; if (bus_err !== 1'b1) begin bad++; $display("FAIL timeout.sticky got=%b exp=1", bus_err); end
        do_reset();
        #1;
        total++; if (bus_err !== 1'b0) begin bad++; $display("FAIL timeout.clear got=%b exp=0", bus_err); end
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_if_read();
        test_store();
        test_streak();
        test_random();
        test_reset_mid();
        test_spurious_ack();
`ifdef MEM_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
